// File: rtl/rtc_escritura_fecha_if.sv
// Bus bundle between the date-adjust counters, the RTC write controller and the RTC pins.
// "master" is the controller's view; "slave" is the surrounding logic's view.
interface rtc_escritura_fecha_if;
    logic       start;
    logic [4:0] cont_dia;
    logic [3:0] cont_mes;
    logic [6:0] cont_year;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        input  start, cont_dia, cont_mes, cont_year,
        output busy, done, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );

    modport slave (
        output start, cont_dia, cont_mes, cont_year,
        input  busy, done, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_escritura_fecha.sv
// Writes the adjusted day/month/year into the RTC as BCD over its multiplexed
// address/data bus: three registers, each an address cycle then a data cycle.
module rtc_escritura_fecha #(
    parameter int         T_FASE   = 4,
    parameter logic [7:0] DIR_DIA  = 8'h24,
    parameter logic [7:0] DIR_MES  = 8'h25,
    parameter logic [7:0] DIR_YEAR = 8'h26
) (
    input  logic                  clk,
    input  logic                  rst,
    rtc_escritura_fecha_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] GAP    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [3:0] CNT_MAX = 4'(T_FASE - 1);

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    logic [2:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] idx, idx_nxt;
    logic       fase, fase_nxt;

    logic [4:0] cap_dia;
    logic [3:0] cap_mes;
    logic [6:0] cap_year;
    logic [7:0] bcd_dia, bcd_mes, bcd_year;
    logic [4:0] sat_dia;
    logic [3:0] sat_mes;
    logic [6:0] sat_year;

    logic       busy_q, done_q, cs_n_q, wr_n_q, ad_sel_q, ad_oe_q;
    logic [7:0] ad_out_q;
    logic       in_bus;
    logic [7:0] addr_sel, data_sel;

    always_comb begin
        sat_dia  = (cap_dia == 5'd0) ? 5'd1 : cap_dia;
        sat_mes  = (cap_mes == 4'd0) ? 4'd1 : ((cap_mes > 4'd12) ? 4'd12 : cap_mes);
        sat_year = (cap_year > 7'd99) ? 7'd99 : cap_year;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        fase_nxt  = fase;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                idx_nxt   = 2'd0;
                fase_nxt  = 1'b0;
                cnt_nxt   = 4'd0;
                state_nxt = SETUP;
            end
            SETUP, STROBE, HOLD: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt = 4'd0;
                    if (state == SETUP)       state_nxt = STROBE;
                    else if (state == STROBE) state_nxt = HOLD;
                    else                      state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                if (!fase) begin
                    fase_nxt  = 1'b1;
                    state_nxt = SETUP;
                end else if (idx < 2'd2) begin
                    idx_nxt   = idx + 2'd1;
                    fase_nxt  = 1'b0;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the RTC pins never glitch.
    always_comb begin
        case (idx_nxt)
            2'd0: begin
                addr_sel = DIR_DIA;
                data_sel = bcd_dia;
            end
            2'd1: begin
                addr_sel = DIR_MES;
                data_sel = bcd_mes;
            end
            default: begin
                addr_sel = DIR_YEAR;
                data_sel = bcd_year;
            end
        endcase
        in_bus = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx      <= 2'd0;
            fase     <= 1'b0;
            cap_dia  <= 5'd0;
            cap_mes  <= 4'd0;
            cap_year <= 7'd0;
            bcd_dia  <= 8'h00;
            bcd_mes  <= 8'h00;
            bcd_year <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            ad_sel_q <= 1'b0;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            fase  <= fase_nxt;
            if (state == IDLE && bus.start) begin
                cap_dia  <= bus.cont_dia;
                cap_mes  <= bus.cont_mes;
                cap_year <= bus.cont_year;
            end
            if (state == LOAD) begin
                bcd_dia  <= to_bcd({2'b00, sat_dia});
                bcd_mes  <= to_bcd({3'b000, sat_mes});
                bcd_year <= to_bcd(sat_year);
            end
            busy_q   <= (state_nxt != IDLE) && (state_nxt != DONE);
            done_q   <= (state_nxt == DONE);
            cs_n_q   <= !in_bus;
            ad_oe_q  <= in_bus;
            wr_n_q   <= (state_nxt != STROBE);
            ad_sel_q <= in_bus && fase_nxt;
            ad_out_q <= in_bus ? (fase_nxt ? data_sel : addr_sel) : 8'h00;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.rd_n   = 1'b1;
    assign bus.wr_n   = wr_n_q;
    assign bus.ad_sel = ad_sel_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
endmodule

// File: tb/tb_rtc_escritura_fecha.sv
// Bench for rtc_escritura_fecha: two instances (T_FASE=4 and T_FASE=1) checked
// against a date-to-BCD write-sequence model and a bus protocol monitor.
module tb_rtc_escritura_fecha;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [4:0] dia = 5'd0;
    logic [3:0] mes = 4'd0;
    logic [6:0] year = 7'd0;

    int total = 0;
    int bad = 0;

    rtc_escritura_fecha_if b4 ();
    rtc_escritura_fecha_if b1 ();

    assign b4.start = start_v[0];
    assign b4.cont_dia = dia;
    assign b4.cont_mes = mes;
    assign b4.cont_year = year;
    assign b1.start = start_v[1];
    assign b1.cont_dia = dia;
    assign b1.cont_mes = mes;
    assign b1.cont_year = year;

    rtc_escritura_fecha #(.T_FASE(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    rtc_escritura_fecha #(.T_FASE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    logic [1:0] wr_n_s, cs_n_s, rd_n_s, busy_s, done_s, oe_s;
    logic [8:0] cur [2];
    assign wr_n_s = {b1.wr_n, b4.wr_n};
    assign cs_n_s = {b1.cs_n, b4.cs_n};
    assign rd_n_s = {b1.rd_n, b4.rd_n};
    assign busy_s = {b1.busy, b4.busy};
    assign done_s = {b1.done, b4.done};
    assign oe_s   = {b1.ad_oe, b4.ad_oe};
    assign cur[0] = {b4.ad_sel, b4.ad_out};
    assign cur[1] = {b1.ad_sel, b1.ad_out};

    // Protocol monitor: records every wr_n low pulse (bus value and length) and
    // counts rule breaks: rd_n low, wr_n low without cs_n, unstable bus around a strobe.
    logic [8:0] pq [$];
    int         lq [$];
    int         viol = 0;
    logic [1:0] prev_wr = 2'b11;
    logic [8:0] last [2];
    logic [8:0] pulse_val [2];
    int         stable [2];
    int         low_len [2];
    int         post_left [2];
    int         tp;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            tp = (i == 0) ? 4 : 1;
            if (!rd_n_s[i]) viol++;
            if (!wr_n_s[i] && cs_n_s[i]) viol++;
            if (cur[i] == last[i]) stable[i]++;
            else stable[i] = 1;
            if (!wr_n_s[i] && prev_wr[i]) begin
                pq.push_back(cur[i]);
                pulse_val[i] = cur[i];
                low_len[i] = 1;
                if (stable[i] < tp + 1) viol++;
            end else if (!wr_n_s[i]) begin
                low_len[i]++;
                if (cur[i] != pulse_val[i]) viol++;
            end else if (!prev_wr[i]) begin
                lq.push_back(low_len[i]);
                if (cur[i] != pulse_val[i]) viol++;
                post_left[i] = tp - 1;
            end else if (post_left[i] > 0) begin
                if (cur[i] != pulse_val[i]) viol++;
                post_left[i]--;
            end
            prev_wr[i] = wr_n_s[i];
            last[i] = cur[i];
        end
    end

    // Reference model: the six (ad_sel, byte) pairs the RTC must see for a date.
    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [8:0] model_pair(input int k, input int d, input int m, input int y);
        int r;
        int v;
        logic [7:0] a;
        r = k / 2;
        case (r)
            0: begin a = 8'h24; v = (d == 0) ? 1 : d; end
            1: begin a = 8'h25; v = (m == 0) ? 1 : ((m > 12) ? 12 : m); end
            default: begin a = 8'h26; v = (y > 99) ? 99 : y; end
        endcase
        return (k % 2 == 0) ? {1'b0, a} : {1'b1, bcd(v)};
    endfunction

    task automatic do_xfer(input int i, input int d, input int m, input int y, input bit retrig);
        int T = (i == 0) ? 4 : 1;
        int exp_done = 2 + 6 * (3 * T + 1);
        int done_at = -1;
        int done_cnt = 0;
        int first_low = -1;
        int busy_bad = 0;
        int viol0;
        logic [8:0] exp_p;
        pq.delete();
        lq.delete();
        viol0 = viol;
        @(negedge clk);
        dia = 5'(d); mes = 4'(m); year = 7'(y);
        start_v[i] = 1'b1;
        for (int n = 1; n <= exp_done + 6; n++) begin
            @(negedge clk);
            if (n == 1) start_v[i] = 1'b0;
            if (busy_s[i] !== ((n < exp_done) ? 1'b1 : 1'b0)) busy_bad++;
            if (done_s[i] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (wr_n_s[i] === 1'b0 && first_low < 0) first_low = n;
            if (retrig && n == 40) begin
                dia = 5'($urandom_range(0, 31));
                mes = 4'($urandom_range(0, 15));
                year = 7'($urandom_range(0, 127));
                start_v[i] = 1'b1;
            end
            if (retrig && n == 41) start_v[i] = 1'b0;
            if (retrig && n == exp_done) start_v[i] = 1'b1;
            if (retrig && n == exp_done + 1) start_v[i] = 1'b0;
        end
        total++;
        if (done_at !== exp_done) begin
            bad++; $display("[TB] FAIL done_cycle inst=%0d got=%0d want=%0d", i, done_at, exp_done);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("[TB] FAIL done_pulses inst=%0d got=%0d want=1", i, done_cnt);
        end
        total++;
        if (first_low !== 2 + T) begin
            bad++; $display("[TB] FAIL first_wr_low inst=%0d got=%0d want=%0d", i, first_low, 2 + T);
        end
        total++;
        if (busy_bad !== 0) begin
            bad++; $display("[TB] FAIL busy_window inst=%0d bad_cycles=%0d want=0", i, busy_bad);
        end
        total++;
        if (pq.size() !== 6 || lq.size() !== 6) begin
            bad++; $display("[TB] FAIL pulse_count inst=%0d got=%0d/%0d want=6", i, pq.size(), lq.size());
        end
        for (int k = 0; k < 6; k++) begin
            exp_p = model_pair(k, d, m, y);
            if (k < pq.size()) begin
                total++;
                if (pq[k] !== exp_p) begin
                    bad++; $display("[TB] FAIL bus_pair inst=%0d k=%0d got=%h want=%h", i, k, pq[k], exp_p);
                end
            end
            if (k < lq.size()) begin
                total++;
                if (lq[k] !== T) begin
                    bad++; $display("[TB] FAIL wr_len inst=%0d k=%0d got=%0d want=%0d", i, k, lq[k], T);
                end
            end
        end
        total++;
        if (viol - viol0 !== 0) begin
            bad++; $display("[TB] FAIL protocol inst=%0d violations=%0d want=0", i, viol - viol0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({b4.busy, b4.done, b4.cs_n, b4.rd_n, b4.wr_n, b4.ad_sel, b4.ad_out, b4.ad_oe}
            !== {2'b00, 3'b111, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("[TB] FAIL reset_t4 got busy=%b done=%b cs_n=%b wr_n=%b out=%h oe=%b want idle values",
                            b4.busy, b4.done, b4.cs_n, b4.wr_n, b4.ad_out, b4.ad_oe);
        end
        total++;
        if ({b1.busy, b1.done, b1.cs_n, b1.rd_n, b1.wr_n, b1.ad_sel, b1.ad_out, b1.ad_oe}
            !== {2'b00, 3'b111, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("[TB] FAIL reset_t1 got busy=%b done=%b cs_n=%b wr_n=%b out=%h oe=%b want idle values",
                            b1.busy, b1.done, b1.cs_n, b1.wr_n, b1.ad_out, b1.ad_oe);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        do_xfer(0, 15, 6, 16, 1'b0);
    endtask

    task automatic test_saturation;
        do_xfer(0, 0, 14, 120, 1'b0);
    endtask

    task automatic test_edges;
        do_xfer(0, 31, 12, 99, 1'b0);
        do_xfer(0, 9, 1, 0, 1'b0);
    endtask

    task automatic test_retrigger;
        do_xfer(0, 22, 9, 45, 1'b1);
    endtask

    task automatic test_protocol_t1;
        do_xfer(1, 15, 6, 16, 1'b0);
        do_xfer(1, 0, 13, 127, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++)
            do_xfer(k % 2, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 127)), 1'b0);
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        dia = 5'd5; mes = 4'd3; year = 7'd7;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (n = 0; n < 200 && done_s[0] !== 1'b1; n++) @(negedge clk);
        total++;
        if (done_s[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_first_done got=%b want=1", done_s[0]);
        end
        @(negedge clk);
        pq.delete();
        dia = 5'd20; mes = 4'd11; year = 7'd50;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        total++;
        if (busy_s[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_accept busy got=%b want=1", busy_s[0]);
        end
        for (n = 0; n < 200 && done_s[0] !== 1'b1; n++) @(negedge clk);
        total++;
        if (pq.size() !== 6) begin
            bad++; $display("[TB] FAIL b2b_pulses got=%0d want=6", pq.size());
        end else begin
            total++;
            if ({pq[1], pq[3], pq[5]} !== {9'h120, 9'h111, 9'h150}) begin
                bad++; $display("[TB] FAIL b2b_data got=%h %h %h want=120 111 150", pq[1], pq[3], pq[5]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        int dn = 0;
        int bz = 0;
        @(negedge clk);
        dia = 5'd15; mes = 4'd6; year = 7'd16;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (29) @(negedge clk);
        for (n = 0; n < 20 && wr_n_s[0] !== 1'b0; n++) @(negedge clk);
        total++;
        if (wr_n_s[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid_strobe wr_n got=%b want=0", wr_n_s[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({wr_n_s[0], cs_n_s[0], busy_s[0], oe_s[0], done_s[0]} !== 5'b11000) begin
            bad++; $display("[TB] FAIL rstmid_outputs got wr_n=%b cs_n=%b busy=%b oe=%b done=%b want 1 1 0 0 0",
                            wr_n_s[0], cs_n_s[0], busy_s[0], oe_s[0], done_s[0]);
        end
        rst = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done_s[0] === 1'b1) dn++;
            if (busy_s[0] !== 1'b0) bz++;
        end
        total++;
        if (dn !== 0 || bz !== 0) begin
            bad++; $display("[TB] FAIL rstmid_after done_pulses=%0d busy_cycles=%0d want 0 0", dn, bz);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last[i] = 9'h000; pulse_val[i] = 9'h000;
            stable[i] = 0; low_len[i] = 0; post_left[i] = 0;
        end
        test_reset();
        test_nominal();
        test_saturation();
        test_edges();
        test_retrigger();
        test_protocol_t1();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
